// File: rtl/icache_s2_if.sv
// rtl/icache_s2_if.sv - line-fill memory port between icache stage 2 and memory
interface icache_s2_if #(
    parameter int ADDR_WIDTH = 32,
    parameter int MEM_WIDTH  = 64
);
    logic                  mem_req_valid;
    logic                  mem_req_ready;
    logic [ADDR_WIDTH-1:0] mem_req_addr;
    logic                  mem_resp_valid;
    logic [MEM_WIDTH-1:0]  mem_resp_data;

    modport master (
        output mem_req_valid, mem_req_addr,
        input  mem_req_ready, mem_resp_valid, mem_resp_data
    );

    modport slave (
        input  mem_req_valid, mem_req_addr,
        output mem_req_ready, mem_resp_valid, mem_resp_data
    );
endinterface

// File: rtl/icache_s2.sv
// rtl/icache_s2.sv - icache stage 2: way compare, hit select, miss refill and replay
module icache_s2 #(
    parameter int ADDR_WIDTH = 32,
    parameter int LINE_WIDTH = 512,
    parameter int CACHE_SET  = 8,
    parameter int TAG_WIDTH  = 24,
    parameter int MEM_WIDTH  = 64,
    localparam int IDX_W     = $clog2(CACHE_SET)
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      Icachestop_i,
    input  logic                      Icacheflush_i,
    input  logic                      s1_valid_i,
    input  logic [ADDR_WIDTH-1:0]     s1_pc_i,
    input  logic [3:0][LINE_WIDTH-1:0] s1_data_i,
    input  logic [3:0][TAG_WIDTH-1:0] s1_tag_i,
    output logic                      hit_valid_o,
    output logic [IDX_W-1:0]          hit_set_o,
    output logic [1:0]                hit_way_o,
    output logic                      refill_valid_o,
    output logic [IDX_W-1:0]          refill_set_o,
    output logic [TAG_WIDTH-1:0]      refill_tag_o,
    output logic [LINE_WIDTH-1:0]     refill_data_o,
    icache_s2_if.master               mem,
    output logic                      miss_stall_o,
    output logic                      redirect_valid_o,
    output logic [ADDR_WIDTH-1:0]     redirect_pc_o,
    output logic                      inst_valid_o,
    output logic [ADDR_WIDTH-1:0]     inst_pc_o,
    output logic [31:0]               inst_o
);
    localparam int BEATS = LINE_WIDTH / MEM_WIDTH;
    localparam int CNT_W = $clog2(BEATS);

    typedef enum logic [2:0] {S_IDLE, S_REQ, S_FILL, S_REFILL, S_REPLAY} state_t;

    state_t                  state_q, state_d;
    logic [ADDR_WIDTH-1:0]   miss_pc_q;
    logic [CNT_W-1:0]        cnt_q;
    logic                    kill_q, kill_d;
    logic [LINE_WIDTH-1:0]   line_buf_q;
    logic                    inst_valid_q;
    logic [ADDR_WIDTH-1:0]   inst_pc_q;
    logic [31:0]             inst_q;

    logic [TAG_WIDTH-1:0]    lookup_tag;
    logic [3:0]              match;
    logic                    hit;
    logic [1:0]              hit_way;
    logic [IDX_W-1:0]        s1_set;
    logic [3:0]              s1_word;
    logic                    lookup_ok, hit_fire, miss_fire;
    logic [31:0]             hit_word, replay_word;
    logic                    unused_pc_bits;

    assign lookup_tag     = {1'b1, s1_pc_i[ADDR_WIDTH-1:9]};
    assign s1_set         = s1_pc_i[6+IDX_W-1:6];
    assign s1_word        = s1_pc_i[5:2];
    assign unused_pc_bits = ^s1_pc_i[1:0];

    // Valid bit is part of the compared tag, so invalid ways can never match.
    always_comb begin
        hit_way = '0;
        for (int i = 0; i < 4; i++) match[i] = (s1_tag_i[i] == lookup_tag);
        for (int i = 3; i >= 0; i--) if (match[i]) hit_way = 2'(i);
    end

    assign hit         = |match;
    assign lookup_ok   = s1_valid_i && !Icachestop_i && !Icacheflush_i && (state_q == S_IDLE);
    assign hit_fire    = lookup_ok && hit;
    assign miss_fire   = lookup_ok && !hit;
    assign hit_word    = s1_data_i[hit_way][{s1_word, 5'b0} +: 32];
    assign replay_word = line_buf_q[{miss_pc_q[5:2], 5'b0} +: 32];

    always_ff @(posedge clk or posedge rst) begin
        if (rst) state_q <= S_IDLE;
        else     state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE:   if (miss_fire) state_d = S_REQ;
            S_REQ:    if (mem.mem_req_ready) state_d = S_FILL;
            S_FILL:   if (mem.mem_resp_valid && cnt_q == CNT_W'(BEATS - 1)) state_d = S_REFILL;
            S_REFILL: state_d = (kill_q || Icacheflush_i) ? S_IDLE : S_REPLAY;
            S_REPLAY: state_d = S_IDLE;
            default:  state_d = S_IDLE;
        endcase
    end

    always_comb begin
        kill_d = kill_q;
        if (state_d == S_IDLE)
            kill_d = 1'b0;
        else if (Icacheflush_i && (state_q == S_REQ || state_q == S_FILL))
            kill_d = 1'b1;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            miss_pc_q    <= '0;
            cnt_q        <= '0;
            kill_q       <= 1'b0;
            line_buf_q   <= '0;
            inst_valid_q <= 1'b0;
            inst_pc_q    <= '0;
            inst_q       <= '0;
        end else begin
            inst_valid_q <= hit_fire;
            inst_pc_q    <= hit_fire ? s1_pc_i : '0;
            inst_q       <= hit_fire ? hit_word : '0;
            kill_q       <= kill_d;
            if (miss_fire) miss_pc_q <= s1_pc_i;
            if (state_q == S_REQ && mem.mem_req_ready) begin
                cnt_q <= '0;
            end else if (state_q == S_FILL && mem.mem_resp_valid) begin
                line_buf_q[{cnt_q, 6'b0} +: MEM_WIDTH] <= mem.mem_resp_data;
                cnt_q <= cnt_q + CNT_W'(1);
            end
        end
    end

    always_comb begin
        hit_valid_o       = hit_fire;
        hit_set_o         = hit_fire ? s1_set : '0;
        hit_way_o         = hit_fire ? hit_way : '0;
        refill_valid_o    = 1'b0;
        refill_set_o      = '0;
        refill_tag_o      = '0;
        refill_data_o     = '0;
        mem.mem_req_valid = 1'b0;
        mem.mem_req_addr  = '0;
        miss_stall_o      = 1'b0;
        redirect_valid_o  = 1'b0;
        redirect_pc_o     = '0;
        inst_valid_o      = inst_valid_q;
        inst_pc_o         = inst_pc_q;
        inst_o            = inst_q;
        case (state_q)
            S_REQ: begin
                mem.mem_req_valid = 1'b1;
                mem.mem_req_addr  = {miss_pc_q[ADDR_WIDTH-1:6], 6'b0};
                miss_stall_o      = 1'b1;
            end
            S_FILL: miss_stall_o = 1'b1;
            S_REFILL: begin
                refill_valid_o = 1'b1;
                refill_set_o   = miss_pc_q[6+IDX_W-1:6];
                refill_tag_o   = {1'b1, miss_pc_q[ADDR_WIDTH-1:9]};
                refill_data_o  = line_buf_q;
                miss_stall_o   = 1'b1;
            end
            // A late flush still cancels the replayed instruction and the restart.
            S_REPLAY: begin
                inst_valid_o     = !Icacheflush_i;
                inst_pc_o        = miss_pc_q;
                inst_o           = replay_word;
                redirect_valid_o = !Icacheflush_i;
                redirect_pc_o    = miss_pc_q + ADDR_WIDTH'(4);
            end
            default: ;
        endcase
    end
endmodule

// File: tb/tb_icache_s2.sv
// tb/tb_icache_s2.sv - self-checking bench for icache_s2
module tb_icache_s2;
    logic                clk = 1'b0;
    logic                rst;
    logic                stop, flush, s1_valid;
    logic [31:0]         s1_pc;
    logic [3:0][511:0]   s1_data;
    logic [3:0][23:0]    s1_tag;
    logic                hit_valid;
    logic [2:0]          hit_set;
    logic [1:0]          hit_way;
    logic                refill_valid;
    logic [2:0]          refill_set;
    logic [23:0]         refill_tag;
    logic [511:0]        refill_data;
    logic                miss_stall, redirect_valid, inst_valid;
    logic [31:0]         redirect_pc, inst_pc, inst;

    int checks = 0;
    int errors = 0;

    icache_s2_if #(.ADDR_WIDTH(32), .MEM_WIDTH(64)) mem_if ();

    icache_s2 dut (
        .clk(clk), .rst(rst),
        .Icachestop_i(stop), .Icacheflush_i(flush),
        .s1_valid_i(s1_valid), .s1_pc_i(s1_pc), .s1_data_i(s1_data), .s1_tag_i(s1_tag),
        .hit_valid_o(hit_valid), .hit_set_o(hit_set), .hit_way_o(hit_way),
        .refill_valid_o(refill_valid), .refill_set_o(refill_set),
        .refill_tag_o(refill_tag), .refill_data_o(refill_data),
        .mem(mem_if),
        .miss_stall_o(miss_stall), .redirect_valid_o(redirect_valid), .redirect_pc_o(redirect_pc),
        .inst_valid_o(inst_valid), .inst_pc_o(inst_pc), .inst_o(inst)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [3:0][23:0] tags;
        logic [31:0]      pc;
        logic             v, stp, fl;
        logic             exp_hit;
        logic [2:0]       exp_set;
        logic [1:0]       exp_way;
        logic [31:0]      exp_inst;
    } vec_t;

    vec_t vecs[9];

    task automatic chk(input string name, input logic [511:0] act, input logic [511:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    function automatic logic [63:0] beat(input int k);
        logic [31:0] w;
        w = 32'h1000 + 32'(k);
        return {w, w};
    endfunction

    function automatic logic [511:0] line_model();
        logic [511:0] l;
        for (int k = 0; k < 8; k++) l[64*k +: 64] = beat(k);
        return l;
    endfunction

    task automatic start_miss(input logic [31:0] pc);
        @(negedge clk);
        s1_tag = '0;
        s1_pc = pc;
        s1_valid = 1'b1;
        @(posedge clk);
        #1 s1_valid = 1'b0;
    endtask

    logic [511:0] exp_line;

    initial begin
        rst = 1'b1; stop = 0; flush = 0; s1_valid = 0; s1_pc = '0; s1_tag = '0;
        mem_if.mem_req_ready = 0; mem_if.mem_resp_valid = 0; mem_if.mem_resp_data = '0;
        for (int w = 0; w < 4; w++)
            for (int j = 0; j < 16; j++)
                s1_data[w][32*j +: 32] = 32'hC0DE_0000 + 32'(w * 256 + j);
        exp_line = line_model();

        // {tag3,tag2,tag1,tag0}, pc, valid, stop, flush, hit, set, way, inst
        vecs[0] = '{{24'h0, 24'h800008, 24'h0, 24'h0}, 32'h0000_1044, 1, 0, 0, 1, 3'd1, 2'd2, 32'hC0DE_0201};
        vecs[1] = '{{24'h800008, 24'h0, 24'h800008, 24'h0}, 32'h0000_1048, 1, 0, 0, 1, 3'd1, 2'd1, 32'hC0DE_0102};
        vecs[2] = '{{4{24'h800010}}, 32'h0000_21FC, 1, 0, 0, 1, 3'd7, 2'd0, 32'hC0DE_000F};
        vecs[3] = '{{24'hFFFFFF, 24'h0, 24'h0, 24'h0}, 32'hFFFF_FFC0, 1, 0, 0, 1, 3'd7, 2'd3, 32'hC0DE_0300};
        vecs[4] = '{{24'h0, 24'h0, 24'h0, 24'h0}, 32'h0000_1044, 1, 1, 0, 0, 3'd0, 2'd0, 32'h0};
        vecs[5] = '{{24'h0, 24'h800008, 24'h0, 24'h0}, 32'h0000_1044, 1, 0, 1, 0, 3'd0, 2'd0, 32'h0};
        vecs[6] = '{{24'h0, 24'h800008, 24'h0, 24'h0}, 32'h0000_1044, 0, 0, 0, 0, 3'd0, 2'd0, 32'h0};
        vecs[7] = '{{24'h0, 24'h0, 24'h0, 24'h800008}, 32'h0000_1044, 1, 1, 0, 0, 3'd0, 2'd0, 32'h0};
        vecs[8] = '{{24'h0, 24'h0, 24'h800008, 24'h0}, 32'h0000_1040, 1, 0, 0, 1, 3'd1, 2'd1, 32'hC0DE_0100};

        @(negedge clk);
        #1;
        chk("rst.hit_valid", hit_valid, 0);
        chk("rst.inst_valid", inst_valid, 0);
        chk("rst.inst", inst, 0);
        chk("rst.miss_stall", miss_stall, 0);
        chk("rst.mem_req_valid", mem_if.mem_req_valid, 0);
        chk("rst.refill_valid", refill_valid, 0);
        chk("rst.redirect_valid", redirect_valid, 0);
        @(negedge clk);
        rst = 1'b0;

        for (int i = 0; i < 9; i++) begin
            @(negedge clk);
            s1_tag = vecs[i].tags; s1_pc = vecs[i].pc; s1_valid = vecs[i].v;
            stop = vecs[i].stp; flush = vecs[i].fl;
            #1;
            chk($sformatf("v%0d.hit_valid", i), hit_valid, vecs[i].exp_hit);
            chk($sformatf("v%0d.hit_set", i), hit_set, vecs[i].exp_set);
            chk($sformatf("v%0d.hit_way", i), hit_way, vecs[i].exp_way);
            @(posedge clk);
            #1 s1_valid = 0; stop = 0; flush = 0;
            @(negedge clk);
            #1;
            chk($sformatf("v%0d.inst_valid", i), inst_valid, vecs[i].exp_hit);
            if (vecs[i].exp_hit) begin
                chk($sformatf("v%0d.inst", i), inst, vecs[i].exp_inst);
                chk($sformatf("v%0d.inst_pc", i), inst_pc, vecs[i].pc);
            end
            chk($sformatf("v%0d.mem_req_valid", i), mem_if.mem_req_valid, 0);
            chk($sformatf("v%0d.miss_stall", i), miss_stall, 0);
        end

        // Cold miss whose tags match except for a clear valid bit, with request backpressure and gapped beats.
        @(negedge clk);
        s1_tag = {4{24'h000008}}; s1_pc = 32'h0000_1048; s1_valid = 1;
        #1 chk("A.hit_valid", hit_valid, 0);
        @(posedge clk);
        #1 s1_valid = 0;
        for (int c = 0; c < 5; c++) begin
            @(negedge clk);
            #1;
            chk($sformatf("A.req_valid%0d", c), mem_if.mem_req_valid, 1);
            chk($sformatf("A.req_addr%0d", c), mem_if.mem_req_addr, 32'h0000_1040);
            chk($sformatf("A.stall%0d", c), miss_stall, 1);
        end
        @(negedge clk);
        mem_if.mem_req_ready = 1;
        @(posedge clk);
        #1 mem_if.mem_req_ready = 0;
        s1_tag = {24'h0, 24'h800008, 24'h0, 24'h0}; s1_pc = 32'h0000_1044; s1_valid = 1;
        @(negedge clk);
        #1 chk("A.no_lookup_in_fill", hit_valid, 0);
        s1_valid = 0;
        for (int k = 0; k < 8; k++) begin
            @(negedge clk);
            mem_if.mem_resp_valid = 1; mem_if.mem_resp_data = beat(k);
            @(posedge clk);
            #1 mem_if.mem_resp_valid = 0; mem_if.mem_resp_data = 64'hDEAD_BEEF_DEAD_BEEF;
            if (k != 7) repeat ($urandom_range(0, 2)) @(posedge clk);
        end
        @(negedge clk);
        #1;
        chk("A.refill_valid", refill_valid, 1);
        chk("A.refill_set", refill_set, 3'd1);
        chk("A.refill_tag", refill_tag, 24'h800008);
        chk("A.refill_data", refill_data, exp_line);
        chk("A.refill_stall", miss_stall, 1);
        @(negedge clk);
        #1;
        chk("A.replay_inst_valid", inst_valid, 1);
        chk("A.replay_inst_pc", inst_pc, 32'h0000_1048);
        chk("A.replay_inst", inst, exp_line[64 +: 32]);
        chk("A.redirect_valid", redirect_valid, 1);
        chk("A.redirect_pc", redirect_pc, 32'h0000_104C);
        chk("A.replay_stall", miss_stall, 0);
        chk("A.replay_refill", refill_valid, 0);
        @(negedge clk);
        #1;
        chk("A.idle_inst_valid", inst_valid, 0);
        chk("A.idle_redirect", redirect_valid, 0);

        // Flush while the fourth beat arrives: refill happens, replay does not.
        mem_if.mem_req_ready = 1;
        start_miss(32'h0000_2F80);
        @(posedge clk);
        #1 mem_if.mem_req_ready = 0;
        for (int k = 0; k < 8; k++) begin
            @(negedge clk);
            mem_if.mem_resp_valid = 1; mem_if.mem_resp_data = beat(k);
            flush = (k == 3);
        end
        @(posedge clk);
        #1 mem_if.mem_resp_valid = 0; flush = 0;
        @(negedge clk);
        #1;
        chk("B.refill_valid", refill_valid, 1);
        chk("B.refill_set", refill_set, 3'd6);
        chk("B.refill_tag", refill_tag, 24'h800017);
        chk("B.refill_data", refill_data, exp_line);
        chk("B.refill_stall", miss_stall, 1);
        @(negedge clk);
        #1;
        chk("B.after_inst_valid", inst_valid, 0);
        chk("B.after_redirect", redirect_valid, 0);
        chk("B.after_stall", miss_stall, 0);
        chk("B.after_refill", refill_valid, 0);

        // Reset during the sixth beat, then stray beats must be ignored.
        mem_if.mem_req_ready = 1;
        start_miss(32'h0000_3000);
        @(posedge clk);
        #1 mem_if.mem_req_ready = 0;
        for (int k = 0; k < 5; k++) begin
            @(negedge clk);
            mem_if.mem_resp_valid = 1; mem_if.mem_resp_data = beat(k);
        end
        @(negedge clk);
        mem_if.mem_resp_data = beat(5);
        #2 rst = 1;
        #1;
        chk("C.rst_stall", miss_stall, 0);
        chk("C.rst_req", mem_if.mem_req_valid, 0);
        @(negedge clk);
        rst = 0;
        for (int s = 0; s < 3; s++) begin
            mem_if.mem_resp_data = beat(6 + s);
            @(posedge clk);
            #1;
            chk($sformatf("C.stray%0d_refill", s), refill_valid, 0);
            chk($sformatf("C.stray%0d_stall", s), miss_stall, 0);
        end
        mem_if.mem_resp_valid = 0;
        @(negedge clk);
        #1;
        chk("C.end_refill", refill_valid, 0);
        chk("C.end_req", mem_if.mem_req_valid, 0);
        chk("C.end_stall", miss_stall, 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
